// File: rtl/biriscv_fetch_queue_pkg.sv
// biriscv_fetch_queue_pkg: shared entry layout, lane-mask builder and parity for the fetch queue
package biriscv_fetch_queue_pkg;
  localparam int INSTR_W = 32;
  localparam int OUT_SLOTS = 2;
  localparam int MAX_LANES = 8;
  localparam int LANE_IDX_W = 3;
  typedef struct packed {
    logic [MAX_LANES*INSTR_W-1:0] instr;
    logic [31:0] pc;
    logic [MAX_LANES-1:0] pred;
    logic fault_fetch;
    logic fault_page;
    logic [MAX_LANES-1:0] mask;
    logic parity;
  } entry_t;
  function automatic logic [MAX_LANES-1:0] build_mask(input logic [LANE_IDX_W-1:0] start, input logic [MAX_LANES-1:0] pred, input int lanes, input logic fault);
    logic [MAX_LANES-1:0] m;
    logic stop;
    m = '0;
    stop = 1'b0;
    for (int i = 0; i < MAX_LANES; i++)
      if (i < lanes && i >= int'(start) && !stop) begin
        m[i] = 1'b1;
        stop = fault | pred[i];
      end
    return m;
  endfunction
  function automatic logic calc_parity(input logic [MAX_LANES*INSTR_W-1:0] instr, input logic [31:0] pc);
    return ^instr ^ ^pc;
  endfunction
endpackage

// File: rtl/biriscv_fetch_queue_lanesel.sv
// biriscv_fetch_queue_lanesel: picks slot0/slot1 lanes from head and head+1 masks
module biriscv_fetch_queue_lanesel
  import biriscv_fetch_queue_pkg::*;
(
  input  logic [MAX_LANES-1:0]  head_mask,
  input  logic [MAX_LANES-1:0]  next_mask,
  input  logic                  head_valid,
  input  logic                  next_valid,
  output logic                  s0_valid,
  output logic [LANE_IDX_W-1:0] s0_lane,
  output logic                  s1_valid,
  output logic                  s1_next,
  output logic [LANE_IDX_W-1:0] s1_lane
);
  always_comb begin
    s0_valid = 1'b0;
    s0_lane = '0;
    s1_valid = 1'b0;
    s1_next = 1'b0;
    s1_lane = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--)
      if (head_valid && head_mask[i]) begin
        s0_valid = 1'b1;
        s0_lane = LANE_IDX_W'(i);
      end
    for (int i = MAX_LANES - 1; i >= 0; i--)
      if (head_valid && head_mask[i] && LANE_IDX_W'(i) > s0_lane) begin
        s1_valid = 1'b1;
        s1_lane = LANE_IDX_W'(i);
      end
    if (!s1_valid)
      for (int i = MAX_LANES - 1; i >= 0; i--)
        if (next_valid && next_mask[i]) begin
          s1_valid = 1'b1;
          s1_next = 1'b1;
          s1_lane = LANE_IDX_W'(i);
        end
  end
endmodule

// File: rtl/biriscv_fetch_queue.sv
// biriscv_fetch_queue: fetch beats in (instr/pc/pred/faults), two in-order decode slots out, level and sticky error status
module biriscv_fetch_queue
  import biriscv_fetch_queue_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int LANE_W = 1,
  parameter int DEPTH = 4,
  parameter int DEPTH_W = 2
)(
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  input  logic [NUM_LANES*INSTR_W-1:0] in_instr_i,
  input  logic [31:0]                  in_pc_i,
  input  logic [NUM_LANES-1:0]         in_pred_i,
  input  logic                         in_fault_fetch_i,
  input  logic                         in_fault_page_i,
  output logic                         in_accept_o,
  input  logic                         inject_i,
  output logic [OUT_SLOTS-1:0]         out_valid_o,
  output logic [OUT_SLOTS*INSTR_W-1:0] out_instr_o,
  output logic [OUT_SLOTS*32-1:0]      out_pc_o,
  output logic [OUT_SLOTS-1:0]         out_pred_o,
  output logic [OUT_SLOTS-1:0]         out_fault_fetch_o,
  output logic [OUT_SLOTS-1:0]         out_fault_page_o,
  input  logic [OUT_SLOTS-1:0]         out_accept_i,
  output logic [DEPTH_W:0]             level_o,
  output logic                         error_o
);
  entry_t mem [DEPTH];
  entry_t we, head, nxt, e1;
  logic [DEPTH_W-1:0] rd_ptr, wr_ptr, nx_ptr;
  logic [DEPTH_W:0] level;
  logic error, v0, v1, s0_v, s1_v, s1_n, viol, bad, perr, a0, a1, push, ret0, ret1;
  logic [LANE_IDX_W-1:0] s0_l, s1_l;
  logic [MAX_LANES-1:0] hm, nm;
  assign nx_ptr = rd_ptr + DEPTH_W'(1);
  assign head = mem[rd_ptr];
  assign nxt = mem[nx_ptr];
  assign v0 = level != '0;
  assign v1 = level > (DEPTH_W+1)'(1);
  assign in_accept_o = level < (DEPTH_W+1)'(DEPTH);
  assign level_o = level;
  assign error_o = error;
  biriscv_fetch_queue_lanesel u_lanesel (
    .head_mask(head.mask), .next_mask(nxt.mask), .head_valid(v0), .next_valid(v1),
    .s0_valid(s0_v), .s0_lane(s0_l), .s1_valid(s1_v), .s1_next(s1_n), .s1_lane(s1_l)
  );
  assign e1 = s1_n ? nxt : head;
  assign out_valid_o = {s1_v, s0_v};
  assign out_instr_o = {e1.instr[s1_l*INSTR_W +: INSTR_W], head.instr[s0_l*INSTR_W +: INSTR_W]};
  assign out_pc_o = {e1.pc + 32'({s1_l, 2'b00}), head.pc + 32'({s0_l, 2'b00})};
  assign out_pred_o = {e1.pred[s1_l], head.pred[s0_l]};
  assign out_fault_fetch_o = {e1.fault_fetch, head.fault_fetch};
  assign out_fault_page_o = {e1.fault_page, head.fault_page};
  always_comb begin
    we = '0;
    we.instr[NUM_LANES*INSTR_W-1:0] = (in_fault_fetch_i | in_fault_page_i) ? '0 : in_instr_i;
    we.pc = in_pc_i & ~32'(NUM_LANES*4-1);
    we.pred[NUM_LANES-1:0] = in_pred_i;
    we.fault_fetch = in_fault_fetch_i;
    we.fault_page = in_fault_page_i;
    we.mask = build_mask(LANE_IDX_W'(in_pc_i[LANE_W+1:2]), we.pred, NUM_LANES, in_fault_fetch_i | in_fault_page_i);
    we.parity = calc_parity(we.instr, we.pc) ^ inject_i;
  end
  always_comb begin
    viol = out_accept_i[1] & ~out_accept_i[0];
    bad = (out_accept_i[0] & ~s0_v) | (out_accept_i[1] & ~s1_v);
    a0 = out_accept_i[0] & s0_v & ~viol & ~flush_i;
    a1 = out_accept_i[1] & s1_v & ~viol & ~flush_i;
    perr = (v0 && calc_parity(head.instr, head.pc) != head.parity) ||
           (s1_v && s1_n && calc_parity(nxt.instr, nxt.pc) != nxt.parity);
    hm = head.mask & ~(a0 ? MAX_LANES'(1) << s0_l : '0) & ~(a1 && !s1_n ? MAX_LANES'(1) << s1_l : '0);
    nm = nxt.mask & ~(a1 && s1_n ? MAX_LANES'(1) << s1_l : '0);
    ret0 = v0 && hm == '0;
    ret1 = ret0 && v1 && nm == '0;
    push = in_valid_i & in_accept_o & ~flush_i;
  end
  // Only masks of occupied entries are rewritten, so a push never collides with a pop update.
  always_ff @(posedge clk) begin
    if (v0) mem[rd_ptr].mask <= hm;
    if (v1) mem[nx_ptr].mask <= nm;
    if (push) mem[wr_ptr] <= we;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      error <= 1'b0;
    end else begin
      error <= error | viol | bad | perr;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level <= '0;
      end else begin
        rd_ptr <= rd_ptr + DEPTH_W'(ret0) + DEPTH_W'(ret1);
        wr_ptr <= wr_ptr + DEPTH_W'(push);
        level <= level + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(ret0) - (DEPTH_W+1)'(ret1);
      end
    end
  end
endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// tb_biriscv_fetch_queue: directed self-checking bench for the fetch queue
module tb_biriscv_fetch_queue;
  logic clk = 0, nrst = 0, flush_i = 0, in_valid_i = 0, in_fault_fetch_i = 0, in_fault_page_i = 0, inject_i = 0;
  logic [63:0] in_instr_i = '0;
  logic [31:0] in_pc_i = '0;
  logic [1:0] in_pred_i = '0, out_accept_i = '0;
  logic in_accept_o, error_o;
  logic [1:0] out_valid_o, out_pred_o, out_fault_fetch_o, out_fault_page_o;
  logic [63:0] out_instr_o, out_pc_o;
  logic [2:0] level_o;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  biriscv_fetch_queue #(.NUM_LANES(2), .LANE_W(1), .DEPTH(4), .DEPTH_W(2)) dut (
    .clk(clk), .nrst(nrst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_instr_i(in_instr_i),
    .in_pc_i(in_pc_i), .in_pred_i(in_pred_i), .in_fault_fetch_i(in_fault_fetch_i),
    .in_fault_page_i(in_fault_page_i), .in_accept_o(in_accept_o), .inject_i(inject_i),
    .out_valid_o(out_valid_o), .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_pred_o(out_pred_o),
    .out_fault_fetch_o(out_fault_fetch_o), .out_fault_page_o(out_fault_page_o),
    .out_accept_i(out_accept_i), .level_o(level_o), .error_o(error_o)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [31:0] pc, input logic [63:0] instr, input logic [1:0] pred);
    in_valid_i = 1;
    in_pc_i = pc;
    in_instr_i = instr;
    in_pred_i = pred;
  endtask
  initial begin
    #3;
    chk("rst_level", 64'(level_o), 0);
    chk("rst_accept", 64'(in_accept_o), 1);
    chk("rst_valid", 64'(out_valid_o), 0);
    chk("rst_error", 64'(error_o), 0);
    step();
    step();
    nrst = 1;
    beat(32'h1000, 64'h00200093_00100013, 2'b00);
    step();
    in_valid_i = 0;
    chk("t1_valid", 64'(out_valid_o), 2'b11);
    chk("t1_pc0", 64'(out_pc_o[31:0]), 32'h1000);
    chk("t1_instr0", 64'(out_instr_o[31:0]), 32'h00100013);
    chk("t1_pc1", 64'(out_pc_o[63:32]), 32'h1004);
    chk("t1_instr1", 64'(out_instr_o[63:32]), 32'h00200093);
    chk("t1_level", 64'(level_o), 1);
    out_accept_i = 2'b11;
    step();
    out_accept_i = 2'b00;
    chk("t1_level_after", 64'(level_o), 0);
    chk("t1_valid_after", 64'(out_valid_o), 0);
    beat(32'h1004, 64'hAAAA0001_BBBB0002, 2'b00);
    step();
    beat(32'h1008, 64'hCCCC0003_DDDD0004, 2'b00);
    step();
    in_valid_i = 0;
    chk("t2_valid", 64'(out_valid_o), 2'b11);
    chk("t2_pc0", 64'(out_pc_o[31:0]), 32'h1004);
    chk("t2_instr0", 64'(out_instr_o[31:0]), 32'hAAAA0001);
    chk("t2_pc1", 64'(out_pc_o[63:32]), 32'h1008);
    chk("t2_instr1", 64'(out_instr_o[63:32]), 32'hDDDD0004);
    chk("t2_level", 64'(level_o), 2);
    out_accept_i = 2'b11;
    step();
    out_accept_i = 2'b00;
    chk("t2_level_after", 64'(level_o), 1);
    chk("t2_valid_after", 64'(out_valid_o), 2'b01);
    chk("t2_pc_left", 64'(out_pc_o[31:0]), 32'h100C);
    chk("t2_instr_left", 64'(out_instr_o[31:0]), 32'hCCCC0003);
    out_accept_i = 2'b01;
    step();
    out_accept_i = 2'b00;
    chk("t2_drained", 64'(level_o), 0);
    for (int i = 0; i < 4; i++) begin
      beat(32'h3000 + 32'(i * 8), {32'h3300_0000 + 32'(i), 32'h3000_0000 + 32'(i)}, 2'b00);
      step();
    end
    chk("t3_full_level", 64'(level_o), 4);
    chk("t3_full_accept", 64'(in_accept_o), 0);
    beat(32'h3020, 64'h5555_5555_5555_5555, 2'b00);
    step();
    chk("t3_held_level", 64'(level_o), 4);
    out_accept_i = 2'b01;
    step();
    chk("t3_half_level", 64'(level_o), 4);
    chk("t3_half_accept", 64'(in_accept_o), 0);
    chk("t3_half_pc0", 64'(out_pc_o[31:0]), 32'h3004);
    chk("t3_half_instr0", 64'(out_instr_o[31:0]), 32'h3300_0000);
    step();
    in_valid_i = 0;
    out_accept_i = 2'b00;
    chk("t3_pop_level", 64'(level_o), 3);
    chk("t3_pop_accept", 64'(in_accept_o), 1);
    chk("t3_pop_pc0", 64'(out_pc_o[31:0]), 32'h3008);
    out_accept_i = 2'b11;
    for (int i = 0; i < 3; i++) step();
    out_accept_i = 2'b00;
    chk("t3_drained", 64'(level_o), 0);
    beat(32'h2000, 64'h22220002_11110001, 2'b01);
    step();
    in_valid_i = 0;
    chk("t4_valid", 64'(out_valid_o), 2'b01);
    chk("t4_instr0", 64'(out_instr_o[31:0]), 32'h11110001);
    chk("t4_pred0", 64'(out_pred_o[0]), 1);
    out_accept_i = 2'b01;
    step();
    out_accept_i = 2'b00;
    chk("t4_drained", 64'(level_o), 0);
    for (int i = 0; i < 3; i++) begin
      beat(32'h4000 + 32'(i * 8), 64'h4444_0000_4444_0000 + 64'(i), 2'b00);
      step();
    end
    chk("t5_level", 64'(level_o), 3);
    beat(32'h4018, 64'h1, 2'b00);
    flush_i = 1;
    out_accept_i = 2'b11;
    step();
    flush_i = 0;
    in_valid_i = 0;
    out_accept_i = 2'b00;
    chk("t5_level", 64'(level_o), 0);
    chk("t5_valid", 64'(out_valid_o), 0);
    chk("t5_accept", 64'(in_accept_o), 1);
    step();
    chk("t5_no_push", 64'(level_o), 0);
    chk("t5_error", 64'(error_o), 0);
    beat(32'h5004, 64'h1234_5678_9ABC_DEF0, 2'b00);
    in_fault_fetch_i = 1;
    step();
    in_valid_i = 0;
    in_fault_fetch_i = 0;
    chk("f_valid", 64'(out_valid_o), 2'b01);
    chk("f_pc0", 64'(out_pc_o[31:0]), 32'h5004);
    chk("f_instr0", 64'(out_instr_o[31:0]), 0);
    chk("f_fault0", 64'(out_fault_fetch_o[0]), 1);
    out_accept_i = 2'b01;
    step();
    out_accept_i = 2'b00;
    chk("f_drained", 64'(level_o), 0);
    chk("f_error", 64'(error_o), 0);
    beat(32'h6000, 64'h6666_0001_6666_0000, 2'b00);
    inject_i = 1;
    step();
    in_valid_i = 0;
    inject_i = 0;
    out_accept_i = 2'b11;
    step();
    out_accept_i = 2'b00;
    chk("p_error", 64'(error_o), 1);
    flush_i = 1;
    step();
    flush_i = 0;
    chk("p_error_flush", 64'(error_o), 1);
    nrst = 0;
    #2;
    chk("p_error_rst", 64'(error_o), 0);
    step();
    nrst = 1;
    out_accept_i = 2'b10;
    step();
    out_accept_i = 2'b00;
    chk("o_error", 64'(error_o), 1);
    chk("o_level", 64'(level_o), 0);
    nrst = 0;
    #2;
    chk("o_error_rst", 64'(error_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/biriscv_fetch_queue.md
Name: biriscv_fetch_queue

Overview:
- Parametrised decoupling queue between fetch and decode in the frontend.
- Accepts fetch beats of NUM_LANES x 32-bit instructions with PC, per-lane branch prediction and fault flags.
- Presents up to two in-order instructions per cycle to the dual-issue decode, and may take them from two different beats.
- Flushes on branch redirect. Carries per-entry parity with a sticky integrity error, the successor to the single frontend error flag.

Parameters:
- NUM_LANES, 2, instructions per fetch beat (power of two, 2..8).
- LANE_W, 1, log2(NUM_LANES).
- DEPTH, 4, beat entries stored (power of two, >=2).
- DEPTH_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- flush_i  in  1  branch redirect; discard all contents
- in_valid_i  in  1  fetch beat valid
- in_instr_i  in  NUM_LANES*32  lane i at bits [32i+31:32i]
- in_pc_i  in  32  PC of first valid lane; bits [LANE_W+1:2] give start lane
- in_pred_i  in  NUM_LANES  predicted-taken per lane
- in_fault_fetch_i  in  1  bus fault on beat
- in_fault_page_i  in  1  page fault on beat
- in_accept_o  out  1  queue can take a beat
- inject_i  in  1  test hook: invert stored parity of the beat written this cycle
- out_valid_o  out  2  slot valid (slot0 = older)
- out_instr_o  out  64  slot k at [32k+31:32k]
- out_pc_o  out  64  slot PCs
- out_pred_o  out  2  slot predicted-taken
- out_fault_fetch_o  out  2  slot fetch fault
- out_fault_page_o  out  2  slot page fault
- out_accept_i  in  2  decode takes slot
- level_o  out  DEPTH_W+1  entries occupied
- error_o  out  1  sticky integrity/protocol error

Behaviour:
- Reset (async, nrst=0):
  - all entries invalid; pointers 0; level_o=0; in_accept_o=1; out_valid_o=0; error_o=0.
  - Reset mid-operation discards contents immediately.
- Push:
  - Occurs when in_valid_i & in_accept_o & !flush_i.
  - Entry stores instr, pc aligned down to NUM_LANES*4, pred, faults, lane mask and parity (XOR over instr and pc, inverted if inject_i).
- Lane mask:
  - Covers lanes from the start lane up to and including the first lane with in_pred_i=1; later lanes are dropped.
  - A faulting beat stores only the start lane, with instr=0.
- in_accept_o = (level < DEPTH), evaluated on the current level. When full, a same-cycle pop does not enable a push.
- Latency: a beat pushed in cycle N is visible on the outputs in N+1. Outputs are combinational from stored state.
- Slot formation:
  - Slot0 = lowest unconsumed valid lane of the head entry.
  - Slot1 = next valid lane of the head entry; otherwise the first valid lane of head+1 if that entry is valid.
  - Slot PC = entry pc + 4*lane.
- Ordering:
  - out_accept_i[1] without out_accept_i[0] is a protocol violation: sets error_o and pops nothing.
  - Accepting a slot whose out_valid_o=0 sets error_o and is ignored.
- Pop:
  - Accepted lanes are cleared from the lane mask.
  - An entry retires (read pointer +1, wraps at DEPTH) when its mask becomes empty. Two entries may retire in one cycle.
- Pointers wrap modulo DEPTH. level_o = writes − retires, saturating never required.
- Flush:
  - flush_i clears all entries and the level in the next cycle.
  - A same-cycle push is dropped and same-cycle accepts are ignored. in_accept_o=1 after a flush.
- Parity:
  - Recomputed for every entry feeding a valid slot.
  - A mismatch sets error_o; the slot is still presented.
  - error_o clears only on reset.

Decomposition:
- Shared package holds:
  - the entry struct (instr, pc, pred, faults, mask, parity);
  - the lane-mask build function;
  - the parity function;
  - the INSTR_W=32 and OUT_SLOTS=2 constants.
- One sub-module, biriscv_fetch_queue_lanesel: find-first/next-valid lane over two entries' masks (combinational), instantiated once.
- Storage and pointers stay in the top module.

Test Plan:
- Push beat pc=0x1000, instr {0x00200093,0x00100013}, no pred; accept both slots next cycle → slot0 pc=0x1000 instr=0x00100013, slot1 pc=0x1004; level 1→0.
- Push pc=0x1004 (start lane 1), then pc=0x1008 → slot0=0x1004, slot1=0x1008 (cross-entry); accept both → level 2→1, head lane mask shows lane1 left.
- Fill 4 beats with no accepts → in_accept_o=0, level_o=4; 5th in_valid_i held is not stored; accept slot0 only → entry not retired, in_accept_o stays 0 until the head entry empties.
- Push beat pc=0x2000 with in_pred_i=2'b01 → only lane0 presented, out_valid_o=2'b01 after pop of prior data; lane1 dropped.
- 3 entries queued, flush_i with simultaneous push and out_accept_i=2'b11 → next cycle level_o=0, out_valid_o=0, in_accept_o=1, nothing popped or pushed.
- Push with inject_i=1 → error_o=1 when that entry feeds a slot; stays 1 after flush; out_accept_i=2'b10 on fresh reset → error_o=1; nrst low → error_o=0.
